// File: rtl/decode_regfile_pipe_if.sv
// Fetch-to-decode, writeback and decode-to-execute signals for the decode stage.
// master drives instructions, writeback and out_ready; slave is the decode stage.
interface decode_regfile_pipe_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     inst;
   logic            flush;
   logic            wb_en;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_rs1_data;
   logic [XLEN-1:0] out_rs2_data;
   logic [4:0]      out_rd;
   logic [XLEN-1:0] out_imm;
   logic [31:0]     out_inst;
   logic            out_illegal;

   modport master (
      output in_valid, inst, flush, wb_en, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd,
             out_imm, out_inst, out_illegal
   );

   modport slave (
      input  in_valid, inst, flush, wb_en, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, out_rs1_data, out_rs2_data, out_rd,
             out_imm, out_inst, out_illegal
   );
endinterface

// File: rtl/decode_regfile_pipe.sv
// Decode stage: register file with writeback bypass, immediate generator and
// pending-write scoreboard, behind a single valid/ready output register.
module decode_regfile_pipe #(
   parameter int              XLEN    = 32,
   parameter int              NREGS   = 32,
   parameter logic [XLEN-1:0] SP_INIT = 'h10000
) (
   input  logic                 clk,
   input  logic                 rst,
   decode_regfile_pipe_if.slave bus
);
   localparam int         AW      = $clog2(NREGS);
   localparam logic [5:0] NREGS_L = 6'(NREGS);

   function automatic logic legal(input logic [4:0] idx);
      return {1'b0, idx} < NREGS_L;
   endfunction

   function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] w);
      logic signed [31:0] v;
      casez (w[6:0])
         7'b00?0011, 7'b1100111: v = {{20{w[31]}}, w[31:20]};
         7'b0100011:             v = {{20{w[31]}}, w[31:25], w[11:7]};
         7'b1100011:             v = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         7'b0?10111:             v = {w[31:12], 12'b0};
         7'b1101111:             v = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         default:                v = '0;
      endcase
      return XLEN'(v);
   endfunction

   logic [XLEN-1:0]        regs [NREGS];
   logic [NREGS-1:0]       pending, pend_nxt;
   logic [6:0]             opcode;
   logic [4:0]             rs1, rs2, rd;
   logic                   rs1_used, rs2_used, writes_rd;
   logic                   pend_rs1, pend_rs2, pend_rd;
   logic                   hazard, illegal, in_ready, fire;
   logic [XLEN-1:0]        rs1_data, rs2_data;

   logic                   vld_p1;
   logic [XLEN-1:0]        rs1_data_p1, rs2_data_p1;
   logic signed [XLEN-1:0] imm_p1;
   logic [4:0]             rd_p1;
   logic [31:0]            inst_p1;
   logic                   illegal_p1;

   assign opcode    = bus.inst[6:0];
   assign rs1       = bus.inst[19:15];
   assign rs2       = bus.inst[24:20];
   assign rd        = bus.inst[11:7];
   assign rs1_used  = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
   assign rs2_used  = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
   assign writes_rd = !(opcode inside {7'b0100011, 7'b1100011});

   // Decode stage p0: operand read with bypass, hazard and illegal-index detection
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (legal(rs1) && rs1 != 5'd0)
         rs1_data = (bus.wb_en && bus.wb_rd == rs1) ? bus.wb_data : regs[rs1[AW-1:0]];
      if (legal(rs2) && rs2 != 5'd0)
         rs2_data = (bus.wb_en && bus.wb_rd == rs2) ? bus.wb_data : regs[rs2[AW-1:0]];
   end

   always_comb begin
      pend_rs1 = legal(rs1) && pending[rs1[AW-1:0]] && !(bus.wb_en && bus.wb_rd == rs1);
      pend_rs2 = legal(rs2) && pending[rs2[AW-1:0]] && !(bus.wb_en && bus.wb_rd == rs2);
      pend_rd  = legal(rd)  && pending[rd[AW-1:0]]  && !(bus.wb_en && bus.wb_rd == rd);
      hazard   = (rs1_used && pend_rs1) || (rs2_used && pend_rs2)
              || (writes_rd && rd != 5'd0 && pend_rd);
      illegal  = (rs1_used && !legal(rs1)) || (rs2_used && !legal(rs2))
              || (writes_rd && !legal(rd));
   end

   assign in_ready = (!vld_p1 || bus.out_ready) && !hazard && !bus.flush;
   assign fire     = bus.in_valid && in_ready;

   // Set after clears so a writer issuing in the same cycle keeps its mark
   always_comb begin
      pend_nxt = pending;
      if (bus.wb_en && legal(bus.wb_rd))
         pend_nxt[bus.wb_rd[AW-1:0]] = 1'b0;
      if (bus.flush && vld_p1 && legal(rd_p1))
         pend_nxt[rd_p1[AW-1:0]] = 1'b0;
      if (fire && writes_rd && rd != 5'd0 && legal(rd))
         pend_nxt[rd[AW-1:0]] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pending <= '0;
      else     pending <= pend_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= (i == 2) ? SP_INIT : '0;
      end else if (bus.wb_en && bus.wb_rd != 5'd0 && legal(bus.wb_rd)) begin
         regs[bus.wb_rd[AW-1:0]] <= bus.wb_data;
      end
   end

   // Output register p1: loads on fire, holds while execute stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         rs1_data_p1 <= '0;
         rs2_data_p1 <= '0;
         imm_p1      <= '0;
         rd_p1       <= '0;
         inst_p1     <= '0;
         illegal_p1  <= 1'b0;
      end else if (fire) begin
         vld_p1      <= 1'b1;
         rs1_data_p1 <= rs1_data;
         rs2_data_p1 <= rs2_data;
         imm_p1      <= imm_gen(bus.inst);
         rd_p1       <= rd;
         inst_p1     <= bus.inst;
         illegal_p1  <= illegal;
      end else if (bus.flush || bus.out_ready) begin
         vld_p1      <= 1'b0;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = vld_p1;
   assign bus.out_rs1_data = rs1_data_p1;
   assign bus.out_rs2_data = rs2_data_p1;
   assign bus.out_imm      = imm_p1;
   assign bus.out_rd       = rd_p1;
   assign bus.out_inst     = inst_p1;
   assign bus.out_illegal  = illegal_p1;
endmodule

// File: tb/tb_decode_regfile_pipe.sv
// Directed bench for decode_regfile_pipe: a 32-register and a 16-register instance,
// bundles checked against an expectation queue filled at each accepted instruction.
module tb_decode_regfile_pipe;
   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [31:0] inst;
      logic        ill;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t stage_a, stage_b;
   logic fired_a, fired_b;

   decode_regfile_pipe_if #(.XLEN(32)) a ();
   decode_regfile_pipe_if #(.XLEN(32)) b ();

   decode_regfile_pipe #(.XLEN(32), .NREGS(32), .SP_INIT(32'h10000)) dut32 (
      .clk(clk), .rst(rst), .bus(a.slave));
   decode_regfile_pipe #(.XLEN(32), .NREGS(16), .SP_INIT(32'h10000)) dut16 (
      .clk(clk), .rst(rst), .bus(b.slave));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t mk(input logic [31:0] r1, input logic [31:0] r2,
                               input logic [4:0] d, input logic [31:0] im,
                               input logic [31:0] ins, input logic il);
      exp_t e;
      e.rs1 = r1; e.rs2 = r2; e.rd = d; e.imm = im; e.inst = ins; e.ill = il;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic cmp(input string who, input exp_t e, input exp_t o);
      chk({who, ".rs1"},  o.rs1,         e.rs1);
      chk({who, ".rs2"},  o.rs2,         e.rs2);
      chk({who, ".rd"},   32'(o.rd),     32'(e.rd));
      chk({who, ".imm"},  o.imm,         e.imm);
      chk({who, ".inst"}, o.inst,        e.inst);
      chk({who, ".ill"},  32'(o.ill),    32'(e.ill));
   endtask

   // Sample both instances mid-cycle, retire/accept, then advance to next negedge
   task automatic tick();
      exp_t o;
      #1;
      if (a.out_valid && a.out_ready) begin
         chk("a.out_expected", 32'(qa.size() != 0), 32'd1);
         if (qa.size() != 0) begin
            o = mk(a.out_rs1_data, a.out_rs2_data, a.out_rd, a.out_imm, a.out_inst, a.out_illegal);
            cmp("a", qa.pop_front(), o);
         end
      end
      if (b.out_valid && b.out_ready) begin
         chk("b.out_expected", 32'(qb.size() != 0), 32'd1);
         if (qb.size() != 0) begin
            o = mk(b.out_rs1_data, b.out_rs2_data, b.out_rd, b.out_imm, b.out_inst, b.out_illegal);
            cmp("b", qb.pop_front(), o);
         end
      end
      fired_a = a.in_valid && a.in_ready;
      fired_b = b.in_valid && b.in_ready;
      if (fired_a) qa.push_back(stage_a);
      if (fired_b) qb.push_back(stage_b);
      @(negedge clk);
   endtask

   task automatic issue_a(input logic [31:0] ins, input exp_t e);
      a.inst = ins; a.in_valid = 1'b1; stage_a = e; fired_a = 1'b0;
      for (int k = 0; k < 20 && !fired_a; k++) tick();
      chk("a.issue_accepted", 32'(fired_a), 32'd1);
      a.in_valid = 1'b0;
   endtask

   task automatic issue_b(input logic [31:0] ins, input exp_t e);
      b.inst = ins; b.in_valid = 1'b1; stage_b = e; fired_b = 1'b0;
      for (int k = 0; k < 20 && !fired_b; k++) tick();
      chk("b.issue_accepted", 32'(fired_b), 32'd1);
      b.in_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] ins;
      logic [31:0] v1, v2;
      a.in_valid = 0; a.inst = 0; a.flush = 0; a.wb_en = 0; a.wb_rd = 0; a.wb_data = 0; a.out_ready = 1;
      b.in_valid = 0; b.inst = 0; b.flush = 0; b.wb_en = 0; b.wb_rd = 0; b.wb_data = 0; b.out_ready = 1;
      fired_a = 0; fired_b = 0; stage_a = '0; stage_b = '0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst.out_valid", 32'(a.out_valid), 32'd0);
      chk("rst.in_ready",  32'(a.in_ready),  32'd1);
      chk("rst.out_imm",   a.out_imm,        32'd0);
      chk("rst.out_inst",  a.out_inst,       32'd0);
      rst = 1'b0;

      // Read every register pair through beq; only x2 holds SP_INIT
      for (int i = 0; i < 32; i += 2) begin
         ins = {7'b0, 5'(i + 1), 5'(i), 3'b000, 5'b0, 7'b1100011};
         v1  = (i == 2) ? 32'h10000 : 32'h0;
         v2  = (i + 1 == 2) ? 32'h10000 : 32'h0;
         issue_a(ins, mk(v1, v2, 5'd0, 32'h0, ins, 1'b0));
      end

      // addi x5,x0,-1
      issue_a(32'hFFF00293, mk(32'h0, 32'h0, 5'd5, 32'hFFFFFFFF, 32'hFFF00293, 1'b0));

      // add x6,x5,x5 stalls on pending x5 until writeback, then takes bypassed 7
      a.inst = 32'h00528333; a.in_valid = 1'b1; fired_a = 1'b0;
      stage_a = mk(32'd7, 32'd7, 5'd6, 32'h0, 32'h00528333, 1'b0);
      #1 chk("raw.in_ready_0", 32'(a.in_ready), 32'd0);
      tick();
      chk("raw.no_fire", 32'(fired_a), 32'd0);
      #1 chk("raw.in_ready_1", 32'(a.in_ready), 32'd0);
      tick();
      a.wb_en = 1'b1; a.wb_rd = 5'd5; a.wb_data = 32'd7;
      #1 chk("raw.ready_on_wb", 32'(a.in_ready), 32'd1);
      tick();
      chk("raw.fired_on_wb", 32'(fired_a), 32'd1);
      a.in_valid = 1'b0;

      // wb x6, then wb to x0 alongside a read of x0 (no bypass of x0)
      a.wb_rd = 5'd6; a.wb_data = 32'h55;
      tick();
      a.wb_rd = 5'd0; a.wb_data = 32'h99;
      issue_a(32'h00600063, mk(32'h0, 32'h55, 5'd0, 32'h0, 32'h00600063, 1'b0));
      a.wb_en = 1'b0;

      // sw x5,-4(x2) and lui x12,0x80000
      issue_a(32'hFE512E23, mk(32'h10000, 32'd7, 5'd28, 32'hFFFFFFFC, 32'hFE512E23, 1'b0));
      issue_a(32'h80000637, mk(32'h0, 32'h0, 5'd12, 32'h80000000, 32'h80000637, 1'b0));
      tick();

      // Backpressure: execute stalls 3 cycles with a new instruction waiting
      a.out_ready = 1'b0;
      issue_a(32'h00300393, mk(32'h0, 32'h0, 5'd7, 32'd3, 32'h00300393, 1'b0));
      a.inst = 32'h00400413; a.in_valid = 1'b1; fired_a = 1'b0;
      stage_a = mk(32'h0, 32'h0, 5'd8, 32'd4, 32'h00400413, 1'b0);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall.in_ready",  32'(a.in_ready),  32'd0);
         chk("stall.out_valid", 32'(a.out_valid), 32'd1);
         chk("stall.out_inst",  a.out_inst,       32'h00300393);
         tick();
      end
      a.out_ready = 1'b1;
      tick();
      chk("stall.release_fire", 32'(fired_a), 32'd1);
      a.in_valid = 1'b0;
      tick();
      chk("stall.queue_empty", 32'(qa.size()), 32'd0);

      // Flush squashes addi x9 held in the output register; dependent addi x10 then issues
      a.out_ready = 1'b0;
      issue_a(32'h00100493, mk(32'h0, 32'h0, 5'd9, 32'd1, 32'h00100493, 1'b0));
      a.inst = 32'h00248513; a.in_valid = 1'b1; fired_a = 1'b0;
      stage_a = mk(32'h0, 32'h10000, 5'd10, 32'd2, 32'h00248513, 1'b0);
      #1 chk("flush.dep_blocked", 32'(a.in_ready), 32'd0);
      a.flush = 1'b1;
      void'(qa.pop_front());
      tick();
      chk("flush.no_fire", 32'(fired_a), 32'd0);
      a.flush = 1'b0;
      #1;
      chk("flush.out_valid", 32'(a.out_valid), 32'd0);
      chk("flush.pending_clr", 32'(a.in_ready), 32'd1);
      tick();
      chk("flush.dep_fired", 32'(fired_a), 32'd1);
      a.in_valid = 1'b0; a.out_ready = 1'b1;
      tick();
      chk("flush.queue_empty", 32'(qa.size()), 32'd0);

      // Asynchronous reset with a bundle held: dropped at once, regs and pending reinitialised
      a.out_ready = 1'b0;
      issue_a(32'h00128593, mk(32'd7, 32'h0, 5'd11, 32'd1, 32'h00128593, 1'b0));
      #2 rst = 1'b1;
      #1 chk("arst.out_valid", 32'(a.out_valid), 32'd0);
      qa.delete();
      @(negedge clk);
      rst = 1'b0; a.out_ready = 1'b1;
      issue_a(32'h00228063, mk(32'h0, 32'h10000, 5'd0, 32'h0, 32'h00228063, 1'b0));
      issue_a(32'h00400413, mk(32'h0, 32'h0, 5'd8, 32'd4, 32'h00400413, 1'b0));
      tick();
      tick();
      chk("a.queue_drained", 32'(qa.size()), 32'd0);

      // 16-register instance: illegal index, no aliasing of pending or writes
      issue_b(32'h002088B3, mk(32'h0, 32'h10000, 5'd17, 32'h0, 32'h002088B3, 1'b1));
      b.inst = 32'h00008063; b.in_valid = 1'b1; fired_b = 1'b0;
      stage_b = mk(32'h0, 32'h0, 5'd0, 32'h0, 32'h00008063, 1'b0);
      #1 chk("e.no_alias_pending", 32'(b.in_ready), 32'd1);
      tick();
      b.in_valid = 1'b0;
      b.wb_en = 1'b1; b.wb_rd = 5'd20; b.wb_data = 32'h1234;
      tick();
      b.wb_rd = 5'd3; b.wb_data = 32'h33;
      tick();
      b.wb_en = 1'b0;
      issue_b(32'hFE418CE3, mk(32'h33, 32'h0, 5'd25, 32'hFFFFFFF8, 32'hFE418CE3, 1'b0));
      issue_b(32'hFFFFF0EF, mk(32'h0, 32'h0, 5'd1, 32'hFFFFFFFE, 32'hFFFFF0EF, 1'b0));
      issue_b(32'h0010006F, mk(32'h0, 32'h0, 5'd0, 32'h800, 32'h0010006F, 1'b0));
      tick();
      tick();
      chk("b.queue_drained", 32'(qb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
